// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: opcodes, ALUOP encodings and the
// decoded control bundle passed from ID into EX.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic op_uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_IMM) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
// Purely combinational.
module hazard_detect
    import rv_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       load_use
);

    logic hit1;
    logic hit2;

    assign uses_rs1 = op_uses_rs1(opcode);
    assign uses_rs2 = op_uses_rs2(opcode);

    assign hit1 = uses_rs1 && (ex_rd == rs1);
    assign hit2 = uses_rs2 && (ex_rd == rs2);

    // x0 is never a real producer, so a load to x0 cannot create a hazard
    assign load_use = ex_valid && ex_memread && (ex_rd != 5'd0) &&
                      id_valid && (hit1 || hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// and saturating bubble/flush event counters.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [31:0]      id_inst,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [1:0]       id_aluop,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             flush,
    input  logic             hold,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [1:0]       ex_aluop,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  load_use;
    logic  uses_rs1;
    logic  uses_rs2;
    logic  unused_inst;

    assign unused_inst = ^{id_inst[31], id_inst[29:25], uses_rs1, uses_rs2};

    assign id_ctrl = '{
        aluop:    id_aluop,
        branch:   id_branch,
        memread:  id_memread,
        memtoreg: id_memtoreg,
        memwrite: id_memwrite,
        alusrc:   id_alusrc,
        regwrite: id_regwrite
    };

    hazard_detect u_hazard (
        .id_valid   (id_valid),
        .opcode     (id_inst[6:0]),
        .rs1        (id_inst[19:15]),
        .rs2        (id_inst[24:20]),
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl.memread),
        .ex_rd      (ex_rd),
        .uses_rs1   (uses_rs1),
        .uses_rs2   (uses_rs2),
        .load_use   (load_use)
    );

    // A flush kills the stalled instruction, so no stall is requested
    assign hazard_stall = load_use && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_ctrl     <= CTRL_BUBBLE;
            bubble_cnt  <= '0;
            flush_cnt   <= '0;
        end else if (flush || (!hold && load_use)) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_ctrl     <= CTRL_BUBBLE;
            if (flush) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else begin
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_inst[19:15];
            ex_rs2      <= id_inst[24:20];
            ex_rd       <= id_inst[11:7];
            ex_funct3   <= id_inst[14:12];
            ex_funct7b5 <= id_inst[30];
            ex_ctrl     <= id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

    assign ex_aluop    = ex_ctrl.aluop;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_regwrite = ex_ctrl.regwrite;

endmodule
